// File: rtl/vx_wb_pkg.sv
// vx_wb_pkg: shared constants, packet type and index helper for the writeback arbiter.
package vx_wb_pkg;

    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_LSU = 1;
    localparam int WB_SRC_CSR = 2;
    localparam int WB_SRC_FPU = 3;
    localparam int WB_SRC_GPU = 4;
    localparam int WB_N_SRC   = 5;

    localparam int WB_NUM_WARPS     = 4;
    localparam int WB_NW_BITS       = (WB_NUM_WARPS > 1) ? $clog2(WB_NUM_WARPS) : 1;
    localparam int WB_NUM_THREADS   = 4;
    localparam int WB_NR_BITS       = 5;
    localparam int WB_DATA_W        = 32;
    localparam int WB_PC_W          = 32;
    localparam int WB_PERF_CTR_BITS = 44;

    typedef struct packed {
        logic [WB_NW_BITS-1:0]               wid;
        logic [WB_PC_W-1:0]                  pc;
        logic [WB_NUM_THREADS-1:0]           tmask;
        logic                                wb;
        logic [WB_NR_BITS-1:0]               rd;
        logic [WB_NUM_THREADS*WB_DATA_W-1:0] data;
        logic                                eop;
    } wb_pkt_t;

    // a in [0, 2n): fold back into [0, n) without a divider
    function automatic int wb_wrap(input int a, input int n);
        return (a >= n) ? a - n : a;
    endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// vx_rr_arbiter: round-robin one-hot arbiter with a packet lock that holds the
// grant on one requester until its end-of-packet beat fires.
module vx_rr_arbiter
    import vx_wb_pkg::*;
#(
    parameter int N = 5,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic [N-1:0]  i_req,
    input  logic [N-1:0]  i_eop,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_idx,
    output logic          o_fire
);

    logic [IW-1:0] r_rr_ptr;
    logic [IW-1:0] r_lock_id;
    logic          r_lock;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        if (r_lock) begin
            o_grant_idx          = r_lock_id;
            o_grant[r_lock_id]   = i_req[r_lock_id];
        end else begin
            // scan farthest-first so the requester nearest rr_ptr is written last
            for (int k = N - 1; k >= 0; k--)
                if (i_req[wb_wrap(int'(r_rr_ptr) + k, N)])
                    o_grant_idx = IW'(wb_wrap(int'(r_rr_ptr) + k, N));
            o_grant[o_grant_idx] = i_req[o_grant_idx];
        end
    end

    assign o_fire = |(i_req & o_grant);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rr_ptr  <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= '0;
        end else if (o_fire) begin
            if (!r_lock)
                r_rr_ptr <= IW'(wb_wrap(int'(o_grant_idx) + 1, N));
            r_lock    <= !i_eop[o_grant_idx];
            r_lock_id <= o_grant_idx;
        end
    end

endmodule

// File: rtl/vx_writeback_arbiter.sv
// vx_writeback_arbiter: round-robin commit arbiter feeding the GPR write port and scoreboard.
// Optional per-source stall counters are built when VX_WB_PERF_EN is defined.
module vx_writeback_arbiter
    import vx_wb_pkg::*;
#(
    parameter int N_SRC       = WB_N_SRC,
    parameter int NUM_WARPS   = WB_NUM_WARPS,
    parameter int NUM_THREADS = WB_NUM_THREADS,
    parameter int NR_BITS     = WB_NR_BITS,
    parameter int DATA_W      = WB_DATA_W,
    parameter int PC_W        = WB_PC_W,
`ifdef VX_WB_PERF_EN
    parameter int PERF_CTR_BITS = WB_PERF_CTR_BITS,
`endif
    localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int IW      = (N_SRC > 1) ? $clog2(N_SRC) : 1,
    localparam int TD_W    = NUM_THREADS * DATA_W
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic [N_SRC-1:0]           i_src_valid,
    output logic [N_SRC-1:0]           o_src_ready,
    input  logic [N_SRC*NW_BITS-1:0]   i_src_wid,
    input  logic [N_SRC*PC_W-1:0]      i_src_pc,
    input  logic [N_SRC*NUM_THREADS-1:0] i_src_tmask,
    input  logic [N_SRC-1:0]           i_src_wb,
    input  logic [N_SRC*NR_BITS-1:0]   i_src_rd,
    input  logic [N_SRC*TD_W-1:0]      i_src_data,
    input  logic [N_SRC-1:0]           i_src_eop,
    output logic                       o_wb_valid,
    output logic [NW_BITS-1:0]         o_wb_wid,
    output logic [PC_W-1:0]            o_wb_pc,
    output logic [NUM_THREADS-1:0]     o_wb_tmask,
    output logic [NR_BITS-1:0]         o_wb_rd,
    output logic [TD_W-1:0]            o_wb_data,
    output logic                       o_wb_eop
`ifdef VX_WB_PERF_EN
    ,
    output logic [N_SRC*PERF_CTR_BITS-1:0] o_perf_wb_stalls
`endif
);

    logic [N_SRC-1:0] w_grant;
    logic [IW-1:0]    w_idx;
    logic             w_fire;

    vx_rr_arbiter #(.N(N_SRC)) u_arb (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_req       (i_src_valid),
        .i_eop       (i_src_eop),
        .o_grant     (w_grant),
        .o_grant_idx (w_idx),
        .o_fire      (w_fire)
    );

    assign o_src_ready = w_grant;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_wb_valid <= 1'b0;
            o_wb_wid   <= '0;
            o_wb_pc    <= '0;
            o_wb_tmask <= '0;
            o_wb_rd    <= '0;
            o_wb_data  <= '0;
            o_wb_eop   <= 1'b0;
        end else begin
            // retire-only packets still consume the slot but never reach the GPR file
            o_wb_valid <= w_fire & i_src_wb[w_idx];
            if (w_fire) begin
                o_wb_wid   <= i_src_wid[w_idx*NW_BITS +: NW_BITS];
                o_wb_pc    <= i_src_pc[w_idx*PC_W +: PC_W];
                o_wb_tmask <= i_src_tmask[w_idx*NUM_THREADS +: NUM_THREADS];
                o_wb_rd    <= i_src_rd[w_idx*NR_BITS +: NR_BITS];
                o_wb_data  <= i_src_data[w_idx*TD_W +: TD_W];
                o_wb_eop   <= i_src_eop[w_idx];
            end
        end
    end

`ifdef VX_WB_PERF_EN
    logic [PERF_CTR_BITS-1:0] r_stalls [N_SRC];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < N_SRC; i++)
                r_stalls[i] <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++)
                if (i_src_valid[i] && !w_grant[i])
                    r_stalls[i] <= r_stalls[i] + PERF_CTR_BITS'(1);
        end
    end

    for (genvar g = 0; g < N_SRC; g++) begin : g_perf
        assign o_perf_wb_stalls[g*PERF_CTR_BITS +: PERF_CTR_BITS] = r_stalls[g];
    end
`endif

endmodule

// File: tb/tb_vx_writeback_arbiter.sv
// tb_vx_writeback_arbiter: table vectors, directed corner sequences and random traffic
// checked against a behavioural round-robin/lock model.
module tb_vx_writeback_arbiter;
    import vx_wb_pkg::*;

    localparam int N  = 5;
    localparam int NT = 4;
    localparam int TD = NT * 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [N-1:0] src_valid = '0, src_wb = '0, src_eop = '0;
    logic [N-1:0] src_ready;
    logic [N*2-1:0] src_wid;
    logic [N*32-1:0] src_pc;
    logic [N*NT-1:0] src_tmask;
    logic [N*5-1:0] src_rd;
    logic [N*TD-1:0] src_data;
    logic wb_valid, wb_eop;
    logic [1:0] wb_wid;
    logic [31:0] wb_pc;
    logic [NT-1:0] wb_tmask;
    logic [4:0] wb_rd;
    logic [TD-1:0] wb_data;
`ifdef VX_WB_PERF_EN
    logic [N*44-1:0] perf;
`endif

    logic [1:0]    s_wid  [N];
    logic [31:0]   s_pc   [N];
    logic [NT-1:0] s_tm   [N];
    logic [4:0]    s_rd   [N];
    logic [TD-1:0] s_data [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            src_wid[i*2 +: 2]     = s_wid[i];
            src_pc[i*32 +: 32]    = s_pc[i];
            src_tmask[i*NT +: NT] = s_tm[i];
            src_rd[i*5 +: 5]      = s_rd[i];
            src_data[i*TD +: TD]  = s_data[i];
        end
    end

    vx_writeback_arbiter dut (
        .i_clk(clk), .i_reset_n(reset_n),
        .i_src_valid(src_valid), .o_src_ready(src_ready),
        .i_src_wid(src_wid), .i_src_pc(src_pc), .i_src_tmask(src_tmask),
        .i_src_wb(src_wb), .i_src_rd(src_rd), .i_src_data(src_data), .i_src_eop(src_eop),
        .o_wb_valid(wb_valid), .o_wb_wid(wb_wid), .o_wb_pc(wb_pc), .o_wb_tmask(wb_tmask),
        .o_wb_rd(wb_rd), .o_wb_data(wb_data), .o_wb_eop(wb_eop)
`ifdef VX_WB_PERF_EN
        , .o_perf_wb_stalls(perf)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    // reference model: spec-level rotation pointer, lock and the expected output register
    int m_ptr = 0, m_lock_id = 0;
    bit m_lock = 0;
    bit exp_valid = 0;
    wb_pkt_t exp_pkt = '0;

    task automatic chk(input string nm, input logic [TD-1:0] act, input logic [TD-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v);
        if (m_lock) return v[m_lock_id] ? m_lock_id : -1;
        for (int k = 0; k < N; k++)
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_lock = 0; m_lock_id = 0; exp_valid = 0; exp_pkt = '0;
    endtask

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            s_wid[i] = 2'($urandom);
            s_pc[i]  = $urandom;
            s_tm[i]  = NT'($urandom);
            s_rd[i]  = 5'($urandom);
            s_data[i] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // called at posedge+1; checks at the following negedge, returns at posedge+1
    task automatic run_cycle(input logic [N-1:0] v, e, w, tg, input bit use_tg);
        int g;
        logic [N-1:0] oh;
        src_valid = v; src_eop = e; src_wb = w;
        @(negedge clk);
        g = pick(v);
        oh = (g >= 0) ? N'(1 << g) : '0;
        chk("ready_model", src_ready, oh);
        if (use_tg) chk("ready_table", src_ready, tg);
        chk("wb_valid", wb_valid, exp_valid);
        chk("wb_wid", wb_wid, exp_pkt.wid);
        chk("wb_pc", wb_pc, exp_pkt.pc);
        chk("wb_tmask", wb_tmask, exp_pkt.tmask);
        chk("wb_rd", wb_rd, exp_pkt.rd);
        chk("wb_data", wb_data, exp_pkt.data);
        chk("wb_eop", wb_eop, exp_pkt.eop);
        if (g >= 0) begin
            if (!m_lock) m_ptr = (g + 1) % N;
            m_lock = !e[g];
            m_lock_id = g;
            exp_valid = w[g];
            exp_pkt = '{wid: s_wid[g], pc: s_pc[g], tmask: s_tm[g], wb: w[g],
                        rd: s_rd[g], data: s_data[g], eop: e[g]};
        end else
            exp_valid = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 0; src_valid = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_ready", src_ready, 0);
        reset_n = 1;
    endtask

    typedef struct {
        logic [N-1:0] v, e, w, g;
    } vec_t;
    vec_t tbl[$];

`ifdef VX_WB_PERF_EN
    logic [N*44-1:0] snap;
`endif

    initial begin
        for (int k = 0; k < 10; k++)
            tbl.push_back('{5'b11111, 5'b11111, 5'b11111, N'(1 << (k % 5))});
        tbl.push_back('{5'b00100, 5'b11111, 5'b11011, 5'b00100});
        tbl.push_back('{5'b00000, 5'b11111, 5'b11111, 5'b00000});
        tbl.push_back('{5'b11111, 5'b11111, 5'b11111, 5'b01000});
        tbl.push_back('{5'b00010, 5'b11101, 5'b11111, 5'b00010});
        tbl.push_back('{5'b00001, 5'b11111, 5'b11111, 5'b00000});
        tbl.push_back('{5'b00001, 5'b11111, 5'b11111, 5'b00000});
        tbl.push_back('{5'b00011, 5'b11101, 5'b11111, 5'b00010});
        tbl.push_back('{5'b00011, 5'b11111, 5'b11111, 5'b00010});
        tbl.push_back('{5'b00011, 5'b11111, 5'b11111, 5'b00001});
        tbl.push_back('{5'b00000, 5'b11111, 5'b11111, 5'b00000});

        rand_fields();
        @(posedge clk);
        #1;
        do_reset();

        // ALU-only single packet with literal fields
        s_wid[WB_SRC_ALU] = 2'd2; s_rd[WB_SRC_ALU] = 5'd5;
        s_data[WB_SRC_ALU] = {4{32'hDEADBEEF}};
        run_cycle(5'b00001, 5'b11111, 5'b11111, 5'b00001, 1);
        chk("t1_valid", wb_valid, 1);
        chk("t1_wid", wb_wid, 2);
        chk("t1_rd", wb_rd, 5);
        chk("t1_data", wb_data, {4{32'hDEADBEEF}});
        run_cycle(5'b00000, 5'b11111, 5'b11111, 5'b00000, 1);
        chk("t1_one_cycle", wb_valid, 0);

        do_reset();
        foreach (tbl[n]) begin
            rand_fields();
            run_cycle(tbl[n].v, tbl[n].e, tbl[n].w, tbl[n].g, 1);
        end

        // async reset while LSU holds the lock with a writeback in flight
        run_cycle(5'b00010, 5'b11101, 5'b11111, 5'b00010, 1);
        chk("t5_pre_valid", wb_valid, 1);
        #2 reset_n = 0;
        #1 chk("t5_async_valid", wb_valid, 0);
        chk("t5_async_data", wb_data, 0);
        model_reset();
        @(posedge clk);
        #1 reset_n = 1;
        run_cycle(5'b11111, 5'b11111, 5'b11111, 5'b00001, 1);

`ifdef VX_WB_PERF_EN
        run_cycle(5'b00010, 5'b11101, 5'b11111, 5'b00010, 1);
        snap = perf;
        repeat (4) run_cycle(5'b01000, 5'b11111, 5'b11111, 5'b00000, 1);
        for (int i = 0; i < N; i++)
            chk($sformatf("perf_%0d", i), perf[i*44 +: 44],
                snap[i*44 +: 44] + ((i == WB_SRC_FPU) ? 44'd4 : 44'd0));
        run_cycle(5'b00010, 5'b11111, 5'b11111, 5'b00010, 1);
`endif

        for (int n = 0; n < 3000; n++) begin
            rand_fields();
            run_cycle(N'($urandom), N'($urandom | $urandom), N'($urandom), '0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
